// File: rtl/flicker_if.sv
// flicker_if: run/RNG/brightness bundle between the flicker controller and its neighbours.
interface flicker_if;
  logic       run;
  logic [3:0] rnd_in;
  logic       rnd_en;
  logic       pwm_out;
  logic [7:0] level;
  logic [7:0] target;
  modport master (output run, rnd_in, input rnd_en, pwm_out, level, target);
  modport slave  (input run, rnd_in, output rnd_en, pwm_out, level, target);
endinterface

// File: rtl/flicker_pwm.sv
// flicker_pwm: candle flicker, random target ramped one LSB per tick onto a PWM pin.
// FLICKER_GAMMA_EN: drive the PWM with (level*level)>>8 instead of level.
module flicker_pwm #(
  parameter int PRESCALE   = 256,
  parameter int MIN_LEVEL  = 96,
  parameter int LEVEL_STEP = 10,
  parameter int HOLD_TICKS = 4
) (
  input logic      clk,
  input logic      reset,
  flicker_if.slave bus_io
);
  localparam int PW = $clog2(PRESCALE);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, RAMP, HOLD} state_e;
  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    pwm_cnt_q, level_q, target_q, duty;
  logic [1:0]    fetch_q;
  logic [HW-1:0] hold_q;
  logic          rnd_en_q, pwm_q, tick;
  logic [11:0]   target_d;
  assign tick     = presc_q == PW'(PRESCALE - 1);
  assign target_d = 12'(MIN_LEVEL) + 12'(bus_io.rnd_in) * 12'(LEVEL_STEP);
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + 1'b1;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= pwm_cnt_q < duty;
    end
  end
`ifdef FLICKER_GAMMA_EN
  logic [15:0] sq_q;
  always_ff @(posedge clk) begin
    if (reset) sq_q <= '0;
    else       sq_q <= 16'(level_q) * 16'(level_q);
  end
  assign duty = sq_q[15:8];
`else
  assign duty = level_q;
`endif
  // run low overrides everything, including a step due on this tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rnd_en_q <= 1'b0;
      level_q  <= '0;
      target_q <= '0;
      fetch_q  <= '0;
      hold_q   <= '0;
    end else if (!bus_io.run) begin
      state_q  <= IDLE;
      rnd_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q  <= FETCH;
          rnd_en_q <= 1'b1;
          fetch_q  <= '0;
        end
        FETCH: begin
          fetch_q <= fetch_q + 2'd1;
          if (fetch_q == 2'd3) begin
            state_q  <= LOAD;
            rnd_en_q <= 1'b0;
          end
        end
        LOAD: begin
          target_q <= target_d > 12'd255 ? 8'hff : target_d[7:0];
          state_q  <= RAMP;
        end
        RAMP: if (tick) begin
          if (level_q == target_q) begin
            state_q <= HOLD;
            hold_q  <= '0;
          end else level_q <= level_q < target_q ? level_q + 8'd1 : level_q - 8'd1;
        end
        HOLD: if (tick) begin
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            state_q  <= FETCH;
            rnd_en_q <= 1'b1;
            fetch_q  <= '0;
          end else hold_q <= hold_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus_io.rnd_en  = rnd_en_q;
  assign bus_io.pwm_out = pwm_q;
  assign bus_io.level   = level_q;
  assign bus_io.target  = target_q;
endmodule

// File: tb/tb_flicker_pwm.sv
// tb_flicker_pwm: nibble-to-target table, random episodes and run/reset corner cases.
module tb_flicker_pwm;
  localparam int P    = 4;
  localparam int HT   = 4;
  localparam int MINL = 96;
  localparam int STEP = 10;
  typedef struct { logic [3:0] nib; int exp_t; } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, fails = 0, cyc = 0;
  logic [3:0] nib = 4'hF, rng_q = 4'h0;
  logic [1:0] k = 2'd0;
  vec_t tbl [6];
  flicker_if bus ();
  flicker_if bus2 ();
  flicker_pwm #(.PRESCALE(P)) dut (.clk(clk), .reset(reset), .bus_io(bus));
  flicker_pwm #(.PRESCALE(P), .MIN_LEVEL(200)) dut2 (.clk(clk), .reset(reset), .bus_io(bus2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // RNG stand-in: each enabled shift brings in the next bit of nib, MSB first
  always @(posedge clk) begin
    if (bus.rnd_en) begin
      rng_q <= {rng_q[2:0], nib[2'd3 - k]};
      k     <= k + 2'd1;
    end else k <= 2'd0;
  end
  assign bus.rnd_in  = rng_q;
  assign bus2.rnd_in = 4'hF;
  assign bus2.run    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_target(input int n, input int minl);
    int t = minl + n * STEP;
    return t > 255 ? 255 : t;
  endfunction

  function automatic int duty_of(input int l);
`ifdef FLICKER_GAMMA_EN
    return (l * l) >> 8;
`else
    return l;
`endif
  endfunction

  task automatic pwm_count(input int lvl, input string name);
    int h = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      h += int'(bus.pwm_out);
    end
    check(name, h, duty_of(lvl));
  endtask

  task automatic wait_rise(input int limit);
    int n = 0;
    while (bus.rnd_en !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.rnd_en !== 1'b1) check("fetch_timeout", bus.rnd_en, 1);
  endtask

  task automatic wait_level(input int v, input int limit);
    int n = 0;
    while (bus.level !== 8'(v) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("reach_level", bus.level, v);
  endtask

  task automatic fetch_len();
    int c = 0;
    while (bus.rnd_en === 1'b1 && c < 10) begin
      c++;
      @(negedge clk);
    end
    check("fetch_len", c, 4);
  endtask

  // one fetch/load/ramp/hold round, ending at the first cycle of the next fetch
  task automatic episode(input logic [3:0] n, input int exp_t);
    int start, last, prev, bad, lim;
    nib = n;
    wait_rise(3000);
    fetch_len();
    @(negedge clk);
    check("target", bus.target, exp_t);
    start = cyc; last = -1; prev = int'(bus.level); bad = 0; lim = 0;
    while (bus.rnd_en !== 1'b1 && lim < 3000) begin
      @(negedge clk);
      lim++;
      if (int'(bus.level) != prev) begin
        if (!((int'(bus.level) == prev + 1 && prev < exp_t) ||
              (int'(bus.level) == prev - 1 && prev > exp_t))) bad++;
        if (last < 0 ? (cyc - start > P) : (cyc - last != P)) bad++;
        last = cyc;
        prev = int'(bus.level);
      end
    end
    check("ramp_steps", bad, 0);
    check("final_level", bus.level, exp_t);
    check("next_fetch", bus.rnd_en, 1);
    if (last >= 0) check("hold_gap", cyc - last, (HT + 1) * P);
  endtask

  initial begin
    int h, e, n;
    tbl[0] = '{4'h5, 146};
    tbl[1] = '{4'hA, 196};
    tbl[2] = '{4'h3, 126};
    tbl[3] = '{4'hC, 216};
    tbl[4] = '{4'h1, 106};
    tbl[5] = '{4'hF, 246};
    bus.run = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    h = 0; e = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      h += int'(bus.pwm_out);
      e += int'(bus.rnd_en);
    end
    check("pwm_level0", h, 0);
    check("idle_park", e, 0);
    reset = 1'b1;
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level", bus.level, 0);
    check("rst_target", bus.target, 0);
    check("rst_pwm", bus.pwm_out, 0);
    reset = 1'b0;
    check("rst_rnd_en", bus.rnd_en, 0);
    @(negedge clk);
    check("fetch_start", bus.rnd_en, 1);
    fetch_len();
    @(negedge clk);
    check("target_F", bus.target, 246);
    wait_level(64, 1000);
    bus.run = 1'b0;
    @(negedge clk);
    check("freeze64_rnd_en", bus.rnd_en, 0);
    check("freeze64_level", bus.level, 64);
    pwm_count(64, "pwm_level64");
    check("freeze64_hold", bus.level, 64);
    bus.run = 1'b1;
    @(negedge clk);
    check("restart_fetch", bus.rnd_en, 1);
    fetch_len();
    @(negedge clk);
    check("restart_target", bus.target, 246);
    wait_level(150, 1000);
    bus.run = 1'b0;
    @(negedge clk);
    check("drop_rnd_en", bus.rnd_en, 0);
    check("drop_level", bus.level, 150);
    check("drop_target", bus.target, 246);
    pwm_count(150, "pwm_level150");
    check("drop_hold", bus.level, 150);
    bus.run = 1'b1;
    @(negedge clk);
    episode(4'hF, 246);
    episode(4'h0, 96);
    for (int i = 0; i < 6; i++) episode(tbl[i].nib, tbl[i].exp_t);
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(15, 0));
      episode(4'(n), exp_target(n, MINL));
    end
    check("sat_target", bus2.target, exp_target(15, 200));
    nib = bus.level < 8'd170 ? 4'hF : 4'h0;
    wait_rise(3000);
    fetch_len();
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_level", bus.level, 0);
    check("midreset_target", bus.target, 0);
    check("midreset_rnd_en", bus.rnd_en, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/flicker_pwm.md
Name: flicker_pwm

Overview:
Consumes the 4-bit pseudorandom nibble from the upstream LFSR and turns it into a smoothly varying candle brightness on a single PWM pin. A control FSM requests fresh random bits and maps each nibble to a target level. It then ramps the current level toward that target one LSB per prescaler tick and holds before fetching again. The block sits directly between the RNG and the LED output pin.

Parameters:
PRESCALE, 256, clk cycles per ramp tick (>=2)
MIN_LEVEL, 96, brightness floor added to every target (0..255)
LEVEL_STEP, 10, brightness units per nibble LSB
HOLD_TICKS, 4, ticks spent in HOLD after the target is reached (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  flicker enable; low parks the FSM in IDLE
rnd_in  in  4  nibble from the RNG (registered source)
rnd_en  out  1  shift-enable to the RNG
pwm_out  out  1  LED drive
level  out  8  current brightness
target  out  8  current target brightness

Behaviour:
- Reset values: state IDLE; rnd_en=0, pwm_out=0, level=0, target=0; prescaler, PWM counter and fetch/hold counters all 0.
- Prescaler: counts 0..PRESCALE-1 continuously (not gated by run). tick=1 for one cycle when the count equals PRESCALE-1, then the count wraps to 0.
- PWM: 8-bit free-running counter pwm_cnt. pwm_out is registered as (pwm_cnt < duty), with duty=level. Level 0 gives a constant low; level 255 gives 255/256 duty. PWM keeps running in every state.
- IDLE: rnd_en=0, level held. If run=1, go to FETCH next cycle.
- FETCH: rnd_en=1 for exactly 4 consecutive cycles, which shifts 4 fresh bits into the RNG. Then go to LOAD.
- LOAD (1 cycle): rnd_en=0. Sample rnd_in. Compute target = MIN_LEVEL + rnd_in*LEVEL_STEP in at least 12 bits, saturated to 255. Register the result in target. Go to RAMP.
- RAMP: acts only on tick.
  - level==target: go to HOLD and clear the hold counter.
  - level<target: level+1.
  - level>target: level-1.
  - level never wraps.
- HOLD: increment the hold counter on each tick. On the tick that completes HOLD_TICKS ticks, go to FETCH.
- run=0 in any non-IDLE state: go to IDLE next cycle, rnd_en=0 that cycle. level and target hold. Re-asserting run restarts from FETCH.
- Reset mid-operation: all values return to reset state on the next edge, regardless of tick or run.
- Simultaneous tick and run falling: run wins and no step is applied.

Optional Feature:
FLICKER_GAMMA_EN
- Defined: duty = (level*level)>>8, an 8-bit approximate gamma correction computed from a registered 16-bit product. This adds one cycle of latency from level to duty. level 255 gives duty 254; level 128 gives duty 64.
- Undefined: duty = level, with no extra latency. The level and target ports are unaffected either way.

Test Plan:
- Reset: assert reset 3 cycles with run=1 -> all outputs 0, rnd_en low the cycle after release. rnd_en then goes high for exactly 4 cycles once run is sampled (IDLE->FETCH).
- Target mapping, defaults: drive rnd_in=0xF during LOAD -> target=246. rnd_in=0x0 -> target=96. With MIN_LEVEL=200, rnd_in=0xF -> target saturates at 255.
- Ramp timing, PRESCALE=4: start at level=0 with target=96 -> level increments once every 4 cycles and reaches 96 after 96 ticks. HOLD then lasts 4 ticks (16 cycles) before rnd_en rises again.
- Downward ramp: level=200, next nibble 0x0 -> level decrements to 96 with no overshoot, then enters HOLD.
- PWM, gamma macro undefined: force level 0 -> pwm_out low for 512 cycles. Level 64 -> exactly 64 high cycles per 256-cycle window. With FLICKER_GAMMA_EN defined, level 128 -> 64 high cycles per window.
- Run/reset mid-ramp: drop run while level=150, target=246 -> IDLE next cycle and level frozen at 150. Re-raise run -> FETCH. Pulse reset mid-RAMP -> level=0 and target=0 the next cycle.
